// File: rtl/intr_pkg.sv
// Shared definitions for the interrupt controller.
//   state_t       : controller FSM encoding
//   VEC_BASE_DEF  : default vector of source 0
//   VEC_STRIDE_DEF: default vector spacing between sources
//   LOST_MAX      : saturation value of the lost-pulse counter
//   vec_calc      : base + idx*stride, the caller truncates to its vector width
package intr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SELECT  = 2'd1,
        POSTED  = 2'd2,
        HOLDOFF = 2'd3
    } state_t;

    localparam logic [7:0] VEC_BASE_DEF   = 8'h40;
    localparam int         VEC_STRIDE_DEF = 4;
    localparam logic [7:0] LOST_MAX       = 8'hFF;

    function automatic int vec_calc(input int base, input int idx, input int stride);
        return base + idx * stride;
    endfunction

endpackage

// File: rtl/intr_prio_enc.sv
// Lowest-index-first priority encoder.
//   i_req : request vector, bit 0 has highest priority
//   o_idx : index of the lowest set bit (0 when none set)
//   o_any : at least one bit of i_req is set
module intr_prio_enc #(
    parameter int NREQ = 8,
    parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] i_req,
    output logic [IDXW-1:0] o_idx,
    output logic            o_any
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = IDXW'(i);
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/intr_ctl.sv
// Prioritising interrupt controller driving the CPU's sintr input.
//   clk, reset   : clock, asynchronous active-low reset
//   req_pulse    : one-cycle request strobes, latched into pending bits
//   int_enable   : gates sintr while a vector is posted
//   mask_we/wdata: mask register load (1 = source masked)
//   clear_all    : clears every pending bit
//   ack          : microcode has read the vector (only honoured while posted)
//   sintr        : interrupt request out
//   vector       : vector of the posted source
//   pending/mask : status
//   lost_count   : saturating count of cycles where a pulse hit a pending source
module intr_ctl
    import intr_pkg::*;
#(
    parameter int              NREQ       = 8,
    parameter int              VECW       = 8,
    parameter logic [VECW-1:0] VEC_BASE   = VECW'(VEC_BASE_DEF),
    parameter int              VEC_STRIDE = VEC_STRIDE_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req_pulse,
    input  logic            int_enable,
    input  logic            mask_we,
    input  logic [NREQ-1:0] mask_wdata,
    input  logic            clear_all,
    input  logic            ack,
    output logic            sintr,
    output logic [VECW-1:0] vector,
    output logic [NREQ-1:0] pending,
    output logic [NREQ-1:0] mask,
    output logic [7:0]      lost_count
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          r_state, w_state_nxt;
    logic [NREQ-1:0] r_pending, r_mask;
    logic [NREQ-1:0] w_clr, w_pend_nxt, w_mask_nxt, w_elig, w_elig_nxt;
    logic [IDXW-1:0] r_cur_idx, w_enc_idx;
    logic            w_enc_any, w_ack_post, w_lost_hit;
    logic [VECW-1:0] r_vector, w_vec_sel;
    logic [7:0]      r_lost;

    assign w_ack_post = ack && (r_state == POSTED);

    // Bits being cleared this edge; a same-cycle req_pulse overrides below.
    always_comb begin
        w_clr = '0;
        if (clear_all)
            w_clr = '1;
        else if (w_ack_post)
            w_clr[r_cur_idx] = 1'b1;
    end

    assign w_pend_nxt = req_pulse | (r_pending & ~w_clr);
    assign w_lost_hit = |(req_pulse & r_pending & ~w_clr);
    assign w_mask_nxt = mask_we ? mask_wdata : r_mask;
    assign w_elig     = r_pending & ~r_mask;
    assign w_elig_nxt = w_pend_nxt & ~w_mask_nxt;

    intr_prio_enc #(.NREQ(NREQ), .IDXW(IDXW)) u_enc (
        .i_req (w_elig),
        .o_idx (w_enc_idx),
        .o_any (w_enc_any)
    );

    assign w_vec_sel = VECW'(vec_calc(int'(VEC_BASE), int'(w_enc_idx), VEC_STRIDE));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (|w_elig) w_state_nxt = SELECT;
            // Abandon the selection if a mask write or clear leaves nothing eligible.
            SELECT:  w_state_nxt = (w_enc_any && |w_elig_nxt) ? POSTED : IDLE;
            // Ack wins over a simultaneous mask write; withdraw needs no ack.
            POSTED:  begin
                if (ack)
                    w_state_nxt = HOLDOFF;
                else if (clear_all || w_mask_nxt[r_cur_idx])
                    w_state_nxt = IDLE;
            end
            HOLDOFF: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        sintr = (r_state == POSTED) && int_enable;
    end

    // Datapath: pending, mask, posted index/vector, lost counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending <= '0;
            r_mask    <= '1;
            r_cur_idx <= '0;
            r_vector  <= VEC_BASE;
            r_lost    <= '0;
        end else begin
            r_pending <= w_pend_nxt;
            r_mask    <= w_mask_nxt;
            if (r_state == SELECT && w_state_nxt == POSTED) begin
                r_cur_idx <= w_enc_idx;
                r_vector  <= w_vec_sel;
            end
            if (w_lost_hit && r_lost != LOST_MAX)
                r_lost <= r_lost + 8'd1;
        end
    end

    assign vector     = r_vector;
    assign pending    = r_pending;
    assign mask       = r_mask;
    assign lost_count = r_lost;

endmodule

// File: doc/intr_ctl.md
Name: intr_ctl

Overview:
- Prioritising interrupt controller that feeds the `sintr` input of the CPU flag/conditional logic.
- Latches one-cycle interrupt pulses from unibus/xbus sources into pending bits.
- Masks and priority-arbitrates them, posts one vector at a time, and holds `sintr` until the microcode acknowledges by reading the vector.
- Gated by `int_enable` from the flag block; software loads the mask via the bus path.

Parameters:
- NREQ, 8: number of request sources; index 0 is highest priority.
- VECW, 8: vector width.
- VEC_BASE, 8'h40: vector of source 0.
- VEC_STRIDE, 4: vector spacing between sources; vector = VEC_BASE + idx*VEC_STRIDE, truncated to VECW.

Ports:
- clk  in  1  system clock, all state on posedge.
- reset  in  1  asynchronous, active-low reset.
- req_pulse  in  NREQ  one-cycle request strobe per source.
- int_enable  in  1  interrupt enable from flag block.
- mask_we  in  1  write strobe for mask register.
- mask_wdata  in  NREQ  new mask; 1 = source masked.
- clear_all  in  1  software clear of all pending bits.
- ack  in  1  one-cycle vector-read acknowledge from microcode.
- sintr  out  1  interrupt request to flag block.
- vector  out  VECW  vector of the posted source.
- pending  out  NREQ  pending bits (status).
- mask  out  NREQ  current mask register.
- lost_count  out  8  saturating count of pulses that hit an already-pending source.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, pending=0, mask=all ones, cur_idx=0.
  - vector=VEC_BASE, lost_count=0, sintr=0.
- Pending bit i (per source, each edge):
  - set if req_pulse[i].
  - else cleared if clear_all, or if (ack in POSTED and i==cur_idx).
  - req_pulse always wins over clear/ack in the same cycle, so no request is lost.
- Lost count: req_pulse[i] while pending[i] is already 1, and pending[i] is not being cleared that cycle, increments lost_count.
  - Increment is by 1 per cycle regardless of how many sources collide.
  - Saturates at 8'hFF.
- Mask: mask_we loads mask_wdata on the edge. Masking never clears pending bits.
- eligible = pending & ~mask (registered values).
- State machine (encoded in the package):
  - IDLE: if eligible != 0 -> SELECT.
  - SELECT: cur_idx <= lowest set index of eligible; vector <= VEC_BASE + idx*VEC_STRIDE; -> POSTED. If eligible became 0 this cycle (mask write or clear_all), -> IDLE and vector is unchanged.
  - POSTED: sintr = int_enable (combinational AND with the state decode). Vector is frozen; higher-priority arrivals do not preempt.
    - ack: clear pending[cur_idx] (subject to the req_pulse-wins rule), -> HOLDOFF.
    - Else if mask[cur_idx] became 1, or clear_all: withdraw, -> IDLE with no ack required.
  - HOLDOFF: one dead cycle for pending to settle, sintr=0, -> IDLE.
- Timing:
  - Latency: pulse in cycle N -> pending set after edge N -> SELECT after N+1 -> sintr high from the cycle after edge N+2, provided int_enable=1.
  - int_enable=0 while POSTED: sintr low, state stays POSTED, vector held; sintr rises as soon as int_enable returns.
  - ack outside POSTED is ignored.
  - mask_we and ack in the same cycle in POSTED: ack takes precedence.
- Ordering: back-to-back acks service sources in ascending index order; minimum 4 cycles per posted interrupt.

Decomposition:
- Package intr_pkg holds:
  - state encoding IDLE/SELECT/POSTED/HOLDOFF;
  - default VEC_BASE and VEC_STRIDE;
  - LOST_MAX=8'hFF.
- Sub-module intr_prio_enc: combinational NREQ-bit lowest-index-first encoder with outputs idx and any.

Test Plan:
- Reset, mask=8'h00, req_pulse=8'h08 -> pending=8'h08; sintr=1 three edges later; vector=8'h4C; ack -> pending=0, sintr=0, back to IDLE after HOLDOFF.
- mask=8'h00, req_pulse=8'h24 in one cycle -> first vector 8'h48 (source 2); after ack, vector 8'h54 (source 5); then pending=0.
- Posted source 5, then req_pulse=8'h01 -> vector stays 8'h54 until ack; next post is 8'h40.
- Posted source 3, int_enable=0 -> sintr=0, vector=8'h4C held; int_enable=1 -> sintr=1 the same cycle.
- Posted source 3, mask_we with 8'h08 -> sintr drops, state IDLE, pending still 8'h08; unmask -> reposted with vector 8'h4C.
- Three pulses on source 1 while pending -> lost_count=3. Ack coinciding with a req_pulse on source 1 -> pending[1] stays 1 and lost_count does not increment. Assert reset mid-POSTED -> all outputs return to reset values immediately.
